// File: rtl/sym_ib_lut_pkg.sv
// Shared definitions for the symmetric IB rank LUT: address-split helpers and loader FSM states.
package sym_ib_lut_pkg;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_FLUSH = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

  // A single slot still needs one offset bit so the port never collapses to zero width.
  function automatic int calc_offset_w(input int multi_frame_num);
    return (multi_frame_num > 1) ? $clog2(multi_frame_num) : 1;
  endfunction

  function automatic int calc_page_w(input int entry_addr, input int multi_frame_num);
    return entry_addr - calc_offset_w(multi_frame_num);
  endfunction

endpackage

// File: rtl/sym_dn_lut_loader_if.sv
// Loader handshake and bank write bus; master = entry source / reader, slave = loader.
interface sym_dn_lut_loader_if #(
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2
) ();
  import sym_ib_lut_pkg::*;

  localparam int OFFSET_W = calc_offset_w(MULTI_FRAME_NUM);
  localparam int PAGE_W   = calc_page_w(ENTRY_ADDR, MULTI_FRAME_NUM);

  logic                       load_start;
  logic [OFFSET_W-1:0]        load_frame;
  logic                       load_abort;
  logic                       in_valid;
  logic [1:0]                 in_data;
  logic                       in_ready;
  logic                       lut_in_bank0;
  logic                       lut_in_bank1;
  logic [PAGE_W-1:0]          page_write_addr;
  logic [OFFSET_W-1:0]        write_addr_offset;
  logic                       we;
  logic                       busy;
  logic                       load_done;
  logic [MULTI_FRAME_NUM-1:0] frame_ready;
  logic [MULTI_FRAME_NUM-1:0] frame_release;

  modport master (
    output load_start, load_frame, load_abort, in_valid, in_data, frame_release,
    input  in_ready, lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset,
           we, busy, load_done, frame_ready
  );

  modport slave (
    input  load_start, load_frame, load_abort, in_valid, in_data, frame_release,
    output in_ready, lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset,
           we, busy, load_done, frame_ready
  );

endinterface

// File: rtl/sym_dn_lut_loader.sv
// Write-side sequencer for the two rank LUT banks: streams one frame slot of 2-bit entries
// into the shared write port and tracks which slots hold a complete, committed frame.
module sym_dn_lut_loader
  import sym_ib_lut_pkg::*;
#(
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2
) (
  input  logic               write_clk,
  input  logic               rst,
  sym_dn_lut_loader_if.slave lif
);

  localparam int OFFSET_W = calc_offset_w(MULTI_FRAME_NUM);
  localparam int PAGE_W   = calc_page_w(ENTRY_ADDR, MULTI_FRAME_NUM);
  localparam logic [PAGE_W-1:0] LAST_PAGE = '1;

  ld_state_e                  state_q;
  logic [OFFSET_W-1:0]        slot_q;
  logic [PAGE_W-1:0]          page_q;
  logic                       we_q;
  logic                       bank0_q;
  logic                       bank1_q;
  logic [PAGE_W-1:0]          waddr_q;
  logic [OFFSET_W-1:0]        woff_q;
  logic [MULTI_FRAME_NUM-1:0] frame_ready_q;
  logic [MULTI_FRAME_NUM-1:0] frame_ready_d;
  logic                       accept;

  assign lif.in_ready = (state_q == LD_LOAD) && !lif.load_abort;
  assign accept       = lif.in_valid && lif.in_ready;

  // Release clears first so a same-cycle DONE set for that slot wins.
  always_comb begin
    frame_ready_d = frame_ready_q & ~lif.frame_release;
    if (state_q == LD_IDLE && lif.load_start) begin
      frame_ready_d[lif.load_frame] = 1'b0;
    end
    if (state_q == LD_DONE) begin
      frame_ready_d[slot_q] = 1'b1;
    end
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state_q       <= LD_IDLE;
      slot_q        <= '0;
      page_q        <= '0;
      we_q          <= 1'b0;
      bank0_q       <= 1'b0;
      bank1_q       <= 1'b0;
      waddr_q       <= '0;
      woff_q        <= '0;
      frame_ready_q <= '0;
    end else begin
      we_q          <= accept;
      frame_ready_q <= frame_ready_d;
      if (accept) begin
        bank0_q <= lif.in_data[0];
        bank1_q <= lif.in_data[1];
        waddr_q <= page_q;
        woff_q  <= slot_q;
        page_q  <= page_q + 1'b1;
      end
      // FLUSH lets the last write commit before DONE publishes the slot as ready.
      case (state_q)
        LD_IDLE: begin
          if (lif.load_start) begin
            state_q <= LD_LOAD;
            slot_q  <= lif.load_frame;
            page_q  <= '0;
          end
        end
        LD_LOAD: begin
          if (lif.load_abort) begin
            state_q <= LD_IDLE;
          end else if (accept && page_q == LAST_PAGE) begin
            state_q <= LD_FLUSH;
          end
        end
        LD_FLUSH: state_q <= LD_DONE;
        LD_DONE:  state_q <= LD_IDLE;
        default:  state_q <= LD_IDLE;
      endcase
    end
  end

  assign lif.we                = we_q;
  assign lif.lut_in_bank0      = bank0_q;
  assign lif.lut_in_bank1      = bank1_q;
  assign lif.page_write_addr   = waddr_q;
  assign lif.write_addr_offset = woff_q;
  assign lif.busy              = (state_q != LD_IDLE);
  assign lif.load_done         = (state_q == LD_DONE);
  assign lif.frame_ready       = frame_ready_q;

endmodule
